// File: rtl/czono_linmap_seq_if.sv
// Control bundle between the CZonotope scheduler / MAC datapath (master side)
// and the linear-image sequencer (slave side).
interface czono_linmap_seq_if #(
    parameter int NMAX  = 3,
    parameter int NRMAX = 3,
    parameter int NGMAX = 15
);
    localparam int WN = $clog2(NMAX + 1);
    localparam int WR = $clog2(NRMAX + 1);
    localparam int WG = $clog2(NGMAX + 1);

    logic          start_i;
    logic [WN-1:0] z_n_i;
    logic [WG-1:0] z_ng_i;
    logic [WN-1:0] r_n_i;
    logic [WR-1:0] r_nr_i;
    logic          mac_ready_i;

    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [WN-1:0] idx_n_o;
    logic [WR-1:0] idx_r_o;
    logic [WG-1:0] idx_g_o;
    logic          phase_o;
    logic          acc_clr_o;
    logic          acc_en_o;
    logic          wr_c_o;
    logic          wr_g_o;

    modport master (
        output start_i, z_n_i, z_ng_i, r_n_i, r_nr_i, mac_ready_i,
        input  busy_o, done_o, err_o, idx_n_o, idx_r_o, idx_g_o,
        input  phase_o, acc_clr_o, acc_en_o, wr_c_o, wr_g_o
    );

    modport slave (
        input  start_i, z_n_i, z_ng_i, r_n_i, r_nr_i, mac_ready_i,
        output busy_o, done_o, err_o, idx_n_o, idx_r_o, idx_g_o,
        output phase_o, acc_clr_o, acc_en_o, wr_c_o, wr_g_o
    );
endinterface

// File: rtl/czono_linmap_seq.sv
// Sequencer for the shared FP MAC computing the constrained-zonotope linear image
// (R*c then R*G): walks n/r/g indices and drives accumulator and write strobes.
module czono_linmap_seq #(
    parameter int NMAX  = 3,
    parameter int NRMAX = 3,
    parameter int NGMAX = 15
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    czono_linmap_seq_if.slave  bus
);
    localparam int WN = $clog2(NMAX + 1);
    localparam int WR = $clog2(NRMAX + 1);
    localparam int WG = $clog2(NGMAX + 1);

    localparam logic [WN-1:0] N_ONE = WN'(1);
    localparam logic [WR-1:0] R_ONE = WR'(1);
    localparam logic [WG-1:0] G_ONE = WG'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_CENTER = 3'd2,
        S_GEN    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [WN-1:0] r_zn;
    logic [WG-1:0] r_zng;
    logic [WN-1:0] r_rn;
    logic [WR-1:0] r_rnr;

    logic [WN-1:0] r_idx_n;
    logic [WR-1:0] r_idx_r;
    logic [WG-1:0] r_idx_g;
    logic [WN-1:0] w_idx_n_next;
    logic [WR-1:0] w_idx_r_next;
    logic [WG-1:0] w_idx_g_next;

    logic          w_last_n;
    logic          w_last_r;
    logic          w_last_g;
    logic          w_dim_err;
    logic          w_loop;
    logic          w_step;

    // Upper-bound checks are done in int so they stay meaningful at any parameter set.
    assign w_dim_err = (r_zn != r_rn)
                     || (r_zn == '0) || (r_zng == '0) || (r_rnr == '0)
                     || (int'(r_zn)  > NMAX)
                     || (int'(r_rnr) > NRMAX)
                     || (int'(r_zng) > NGMAX);

    assign w_last_n = (r_idx_n == r_zn  - N_ONE);
    assign w_last_r = (r_idx_r == r_rnr - R_ONE);
    assign w_last_g = (r_idx_g == r_zng - G_ONE);
    assign w_loop   = (r_state == S_CENTER) || (r_state == S_GEN);
    assign w_step   = w_loop && bus.mac_ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_zn  <= '0;
            r_zng <= '0;
            r_rn  <= '0;
            r_rnr <= '0;
        end else if (r_state == S_IDLE && bus.start_i) begin
            r_zn  <= bus.z_n_i;
            r_zng <= bus.z_ng_i;
            r_rn  <= bus.r_n_i;
            r_rnr <= bus.r_nr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_idx_n <= '0;
            r_idx_r <= '0;
            r_idx_g <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx_n <= w_idx_n_next;
            r_idx_r <= w_idx_r_next;
            r_idx_g <= w_idx_g_next;
        end
    end

    // Indices wrap back to zero on every loop exit, so CENTER and GEN both start at 0.
    always_comb begin
        w_state_next = r_state;
        w_idx_n_next = r_idx_n;
        w_idx_r_next = r_idx_r;
        w_idx_g_next = r_idx_g;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                w_state_next = w_dim_err ? S_ERR : S_CENTER;
            end
            S_CENTER: begin
                if (bus.mac_ready_i) begin
                    if (!w_last_n) begin
                        w_idx_n_next = r_idx_n + N_ONE;
                    end else begin
                        w_idx_n_next = '0;
                        if (!w_last_r) begin
                            w_idx_r_next = r_idx_r + R_ONE;
                        end else begin
                            w_idx_r_next = '0;
                            w_state_next = S_GEN;
                        end
                    end
                end
            end
            S_GEN: begin
                if (bus.mac_ready_i) begin
                    if (!w_last_n) begin
                        w_idx_n_next = r_idx_n + N_ONE;
                    end else begin
                        w_idx_n_next = '0;
                        if (!w_last_r) begin
                            w_idx_r_next = r_idx_r + R_ONE;
                        end else begin
                            w_idx_r_next = '0;
                            if (!w_last_g) begin
                                w_idx_g_next = r_idx_g + G_ONE;
                            end else begin
                                w_idx_g_next = '0;
                                w_state_next = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o    = (r_state == S_CHECK) || w_loop;
        bus.done_o    = (r_state == S_DONE);
        bus.err_o     = (r_state == S_ERR);
        bus.phase_o   = (r_state == S_GEN);
        bus.idx_n_o   = w_loop ? r_idx_n : '0;
        bus.idx_r_o   = w_loop ? r_idx_r : '0;
        bus.idx_g_o   = w_loop ? r_idx_g : '0;
        bus.acc_en_o  = w_step;
        bus.acc_clr_o = w_step && (r_idx_n == '0);
        bus.wr_c_o    = w_step && (r_state == S_CENTER) && w_last_n;
        bus.wr_g_o    = w_step && (r_state == S_GEN) && w_last_n;
    end

endmodule
